// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Parametrised UART transmitter with an internal baud divider, a valid/ready
//   input handshake and a one-entry holding register. Because of the holding
//   register, back-to-back frames go out with no idle gap between them.
//
//   Parameters
//     DATA_BITS    data bits per frame (5..9)
//     PARITY       0 = none, 1 = odd, 2 = even
//     STOP_BITS    stop bits per frame (1 or 2)
//     CLKS_PER_BIT clk cycles per bit period (>= 2)
//
//   Ports
//     clk          system clock, rising edge
//     rst_n        asynchronous active-low reset
//     tx_data      word to send; sampled only on handshake
//     tx_valid     tx_data valid
//     tx_ready     holding register empty (handshake = tx_valid && tx_ready)
//     uart_tx_pin  registered serial line, idle high
//     busy         frame in progress or word pending
module uart_transmitter #(
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 uart_tx_pin,
   output logic                 busy
);

   localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        baud_cnt;
   logic [3:0]           bit_idx;
   logic [DATA_BITS-1:0] shifter;
   logic [DATA_BITS-1:0] hold_data;
   logic                 hold_valid;
   logic                 par_bit;
   logic                 pin_q, pin_nxt;
   logic                 bit_end;
   logic                 load;
   logic                 take;

   assign bit_end = (baud_cnt == CNT_LAST);
   // Capture and drain are mutually exclusive: capture needs hold empty,
   // drain needs hold full.
   assign take    = tx_valid && !hold_valid;

   always_comb begin
      state_nxt = state;
      pin_nxt   = pin_q;
      load      = 1'b0;
      case (state)
         S_IDLE: begin
            pin_nxt = 1'b1;
            if (hold_valid) begin
               load      = 1'b1;
               state_nxt = S_START;
               pin_nxt   = 1'b0;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_nxt = S_DATA;
               pin_nxt   = shifter[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx == DATA_LAST) begin
                  state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                  pin_nxt   = (PARITY != 0) ? par_bit : 1'b1;
               end else begin
                  pin_nxt = shifter[0];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_nxt = S_STOP;
               pin_nxt   = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end && bit_idx == STOP_LAST) begin
               // Pending word chains straight into the next start bit.
               if (hold_valid) begin
                  load      = 1'b1;
                  state_nxt = S_START;
                  pin_nxt   = 1'b0;
               end else begin
                  state_nxt = S_IDLE;
                  pin_nxt   = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            pin_nxt   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         pin_q <= 1'b1;
      end else begin
         state <= state_nxt;
         pin_q <= pin_nxt;
      end
   end

   // Baud counter is held at 0 in IDLE so the first start bit is a full period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         shifter  <= '0;
         par_bit  <= 1'b0;
      end else begin
         if (state == S_IDLE || bit_end || load) baud_cnt <= '0;
         else                                    baud_cnt <= baud_cnt + 1'b1;

         if (bit_end) begin
            if (state == S_DATA)
               bit_idx <= (bit_idx == DATA_LAST) ? 4'd0 : bit_idx + 4'd1;
            else if (state == S_STOP)
               bit_idx <= (bit_idx == STOP_LAST) ? 4'd0 : bit_idx + 4'd1;
         end

         // pin_nxt takes shifter[0] on the same edge, so shift after use.
         if (load) begin
            shifter <= hold_data;
            par_bit <= (^hold_data) ^ (PARITY == 1);
         end else if (bit_end && (state == S_START || state == S_DATA)) begin
            shifter <= shifter >> 1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (take) begin
         hold_valid <= 1'b1;
         hold_data  <= tx_data;
      end else if (load) begin
         hold_valid <= 1'b0;
      end
   end

   assign tx_ready    = !hold_valid;
   assign uart_tx_pin = pin_q;
   assign busy        = (state != S_IDLE) || hold_valid;

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter. Three instances (8N1/4, 7E2/4, 7O1/3) run in
// parallel. A line-level model expands every accepted word into its expected
// per-cycle pin levels and is compared cycle by cycle with pin, ready and busy.
module tb_uart_transmitter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data [3];
   logic [2:0] tx_valid;
   logic [2:0] tx_ready;
   logic [2:0] pin;
   logic [2:0] busy;

   int n_assert = 0;
   int n_fail   = 0;

   // model state
   logic       expq   [3][$];
   logic [7:0] offer  [3][$];
   logic       hold_m [3];
   logic [7:0] hold_d [3];
   logic       pin_h  [3][$];
   logic       rdy_h  [3][$];
   logic       bsy_h  [3][$];

   always #5 clk = ~clk;

   uart_transmitter #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) u0 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .uart_tx_pin(pin[0]), .busy(busy[0]));
   uart_transmitter #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(4)) u1 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1][6:0]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .uart_tx_pin(pin[1]), .busy(busy[1]));
   uart_transmitter #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(3)) u2 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2][6:0]), .tx_valid(tx_valid[2]),
      .tx_ready(tx_ready[2]), .uart_tx_pin(pin[2]), .busy(busy[2]));

   function automatic int dbits(int i); return (i == 0) ? 8 : 7; endfunction
   function automatic int par(int i);   return (i == 0) ? 0 : (i == 1) ? 2 : 1; endfunction
   function automatic int stops(int i); return (i == 1) ? 2 : 1; endfunction
   function automatic int cpb(int i);   return (i == 2) ? 3 : 4; endfunction

   task automatic chk(string tag, logic obs, logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Expand one word into its line levels, one entry per clock cycle.
   task automatic build_frame(int i, logic [7:0] d);
      int   ones;
      logic p;
      ones = 0;
      for (int k = 0; k < cpb(i); k++) expq[i].push_back(1'b0);
      for (int b = 0; b < dbits(i); b++) begin
         if (d[b]) ones++;
         for (int k = 0; k < cpb(i); k++) expq[i].push_back(d[b]);
      end
      if (par(i) != 0) begin
         p = (ones % 2 == 1);
         if (par(i) == 1) p = !p;
         for (int k = 0; k < cpb(i); k++) expq[i].push_back(p);
      end
      for (int k = 0; k < cpb(i) * stops(i); k++) expq[i].push_back(1'b1);
   endtask

   task automatic tick();
      logic pre, act;
      logic ep [3];
      logic er [3];
      logic eb [3];
      for (int i = 0; i < 3; i++) begin
         if (offer[i].size() > 0) begin
            tx_valid[i] = 1'b1;
            tx_data[i]  = offer[i][0];
         end else begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = 8'($urandom);
         end
      end
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         ep[i] = 1'b1; er[i] = 1'b1; eb[i] = 1'b0;
         if (rst_n) begin
            pre = hold_m[i];
            act = 1'b0;
            if (expq[i].size() == 0 && hold_m[i]) begin
               build_frame(i, hold_d[i]);
               hold_m[i] = 1'b0;
            end
            if (expq[i].size() > 0) begin
               ep[i] = expq[i].pop_front();
               act   = 1'b1;
            end
            if (tx_valid[i] && !pre) begin
               hold_m[i] = 1'b1;
               hold_d[i] = offer[i].pop_front();
            end
            er[i] = !hold_m[i];
            eb[i] = act || hold_m[i];
         end
      end
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("pin%0d", i),   pin[i],      ep[i]);
         chk($sformatf("ready%0d", i), tx_ready[i], er[i]);
         chk($sformatf("busy%0d", i),  busy[i],     eb[i]);
         pin_h[i].push_back(pin[i]);
         rdy_h[i].push_back(tx_ready[i]);
         bsy_h[i].push_back(busy[i]);
      end
   endtask

   function automatic bit pending();
      for (int i = 0; i < 3; i++)
         if (offer[i].size() > 0 || hold_m[i] || expq[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain();
      int n;
      n = 0;
      while (pending() && n < 3000) begin
         tick();
         n++;
      end
      n_assert++;
      assert (n < 3000) else begin
         n_fail++;
         $error("FAIL drain_timeout: observed %0d cycles expected < 3000", n);
      end
      tick();
   endtask

   task automatic clear_hist();
      for (int i = 0; i < 3; i++) begin
         pin_h[i].delete(); rdy_h[i].delete(); bsy_h[i].delete();
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 3; i++) begin
         expq[i].delete(); offer[i].delete(); hold_m[i] = 1'b0;
      end
   endtask

   initial begin
      logic [9:0]  pat0;
      logic [10:0] pat1;
      logic [9:0]  pat2;
      logic [7:0]  v;
      rst_n    = 1'b0;
      tx_valid = '0;
      for (int i = 0; i < 3; i++) begin
         tx_data[i] = '0; hold_m[i] = 1'b0; hold_d[i] = '0;
      end

      // reset state
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (3) tick();

      // single frames: 8N1 0xA5, 7E2 0x55, 7O1 0x55
      clear_hist();
      offer[0].push_back(8'hA5);
      offer[1].push_back(8'h55);
      offer[2].push_back(8'h55);
      repeat (50) tick();
      pat0 = 10'b1101001010;
      pat1 = 11'b11010101010;
      pat2 = 10'b1110101010;
      chk("a5_latency_pre", pin_h[0][0], 1'b1);
      chk("a5_latency_fall", pin_h[0][1], 1'b0);
      for (int b = 0; b < 10; b++) chk($sformatf("a5_bit%0d", b), pin_h[0][1 + 4*b + 2], pat0[b]);
      for (int b = 0; b < 11; b++) chk($sformatf("7e2_bit%0d", b), pin_h[1][1 + 4*b + 2], pat1[b]);
      for (int b = 0; b < 10; b++) chk($sformatf("7o1_bit%0d", b), pin_h[2][1 + 3*b + 1], pat2[b]);
      chk("a5_ready_low", rdy_h[0][0], 1'b0);
      chk("a5_ready_back", rdy_h[0][1], 1'b1);
      chk("a5_busy_end", bsy_h[0][40], 1'b1);
      chk("a5_busy_fall", bsy_h[0][41], 1'b0);
      chk("7e2_busy_end", bsy_h[1][44], 1'b1);
      chk("7e2_busy_fall", bsy_h[1][45], 1'b0);

      // back-to-back 0x00 then 0xFF
      clear_hist();
      offer[0].push_back(8'h00);
      offer[0].push_back(8'hFF);
      repeat (90) tick();
      chk("b2b_last_stop", pin_h[0][40], 1'b1);
      chk("b2b_next_start", pin_h[0][41], 1'b0);
      chk("b2b_second_data", pin_h[0][47], 1'b1);
      chk("b2b_busy_gap", bsy_h[0][41], 1'b1);
      chk("b2b_busy_end", bsy_h[0][80], 1'b1);
      chk("b2b_idle_after", bsy_h[0][81], 1'b0);

      // backpressure: three words offered continuously
      clear_hist();
      offer[0].push_back(8'h12);
      offer[0].push_back(8'h34);
      offer[0].push_back(8'h56);
      repeat (130) tick();
      chk("bp_ready_full", rdy_h[0][40], 1'b0);
      chk("bp_ready_drain", rdy_h[0][41], 1'b1);
      chk("bp_third_taken", rdy_h[0][42], 1'b0);

      // data stability: tx_data randomised every cycle after the handshake
      clear_hist();
      v = 8'h3C;
      offer[0].push_back(v);
      repeat (45) tick();
      for (int b = 0; b < 8; b++) chk($sformatf("3c_bit%0d", b), pin_h[0][1 + 4*(b+1) + 2], v[b]);

      // random traffic with random gaps
      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < 3; i++)
            if ($urandom_range(0, 1) == 1) offer[i].push_back(8'($urandom));
         repeat ($urandom_range(1, 40)) tick();
      end
      drain();

      // reset mid-frame
      for (int i = 0; i < 3; i++) begin
         offer[i].push_back(8'($urandom));
         offer[i].push_back(8'($urandom));
      end
      repeat (15) tick();
      #1 rst_n = 1'b0;
      #1;
      clear_model();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_pin%0d", i),   pin[i],      1'b1);
         chk($sformatf("rst_ready%0d", i), tx_ready[i], 1'b1);
         chk($sformatf("rst_busy%0d", i),  busy[i],     1'b0);
      end
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
